// File: rtl/fu_arb_pkg.sv
// Shared defaults, FSM state encoding and flag layout for the FU arbiter.
package fu_arb_pkg;

  localparam int FU_WIDTH = 32;
  localparam int FU_FSW   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fu_state_e;

  // Field order fixes the bit order of rsp_flags: {V,C,N,Z}, Z in bit 0.
  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } fu_flags_t;

  function automatic fu_flags_t pack_flags(input logic v, input logic c,
                                           input logic n, input logic z);
    fu_flags_t f;
    f.v = v;
    f.c = c;
    f.n = n;
    f.z = z;
    return f;
  endfunction

endpackage

// File: rtl/fu_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the side
// named by ptr. Purely combinational; the pointer lives in the caller.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/fu_arbiter.sv
// Shares one combinational ALU/shifter between two requesters, round-robin,
// one operation in flight. Build with FU_ARB_LOCK_EN to add owner lock inputs.
module fu_arbiter
  import fu_arb_pkg::*;
#(
  parameter int WIDTH = FU_WIDTH,
  parameter int FSW   = FU_FSW
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [FSW-1:0]   req0_fs,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [FSW-1:0]   req1_fs,
`ifdef FU_ARB_LOCK_EN
  input  logic             req0_lock,
  input  logic             req1_lock,
`endif

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic [3:0]       rsp_flags,

  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  output logic [FSW-1:0]   fu_fs,
  input  logic [WIDTH-1:0] fu_f,
  input  logic             fu_v,
  input  logic             fu_c,
  input  logic             fu_n,
  input  logic             fu_z,

  output logic             busy
);

  fu_state_e        state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] fu_a_q, fu_a_d;
  logic [WIDTH-1:0] fu_b_q, fu_b_d;
  logic [FSW-1:0]   fu_fs_q, fu_fs_d;
  logic [WIDTH-1:0] rsp_f_q, rsp_f_d;
  fu_flags_t        rsp_flags_q, rsp_flags_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

  logic [1:0]       gnt;
  logic             owner_lock;
  logic             owner_rsp_ready;

  rr_arb2 u_rr_arb2 (
    .req ({req1_valid, req0_valid}),
    .ptr (ptr_q),
    .gnt (gnt)
  );

`ifdef FU_ARB_LOCK_EN
  assign owner_lock = owner_q ? req1_lock : req0_lock;
`else
  assign owner_lock = 1'b0;
`endif

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    fu_fs_d     = fu_fs_q;
    rsp_f_d     = rsp_f_q;
    rsp_flags_d = rsp_flags_q;
    rsp_valid_d = rsp_valid_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready is masked during reset so a requester never sees an accept
        // that the reset is about to throw away.
        if (!rst) begin
          req0_ready = gnt[0];
          req1_ready = gnt[1];
        end
        if (|gnt) begin
          fu_a_d  = gnt[1] ? req1_a  : req0_a;
          fu_b_d  = gnt[1] ? req1_b  : req0_b;
          fu_fs_d = gnt[1] ? req1_fs : req0_fs;
          owner_d = gnt[1];
          ptr_d   = ~gnt[1];
          state_d = EXEC;
        end
      end

      EXEC: begin
        rsp_f_d     = fu_f;
        rsp_flags_d = pack_flags(fu_v, fu_c, fu_n, fu_z);
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end

      RESP: begin
        if (owner_rsp_ready) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
          // A locked owner takes the priority back that it gave up at grant.
          if (owner_lock) begin
            ptr_d = owner_q;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        rsp_valid_d = 2'b00;
      end
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the values that were present before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      fu_fs_q     <= '0;
      rsp_f_q     <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
      fu_fs_q     <= fu_fs_d;
      rsp_f_q     <= rsp_f_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign fu_a       = fu_a_q;
  assign fu_b       = fu_b_q;
  assign fu_fs      = fu_fs_q;
  assign rsp_f      = rsp_f_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fu_arbiter.sv
// Bench for fu_arbiter with an adder FU stub and a scoreboard of expected
// responses. Define FU_ARB_LOCK_EN to also exercise the owner lock.
module tb_fu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_fs = '0, req1_fs = '0;
`ifdef FU_ARB_LOCK_EN
  logic        req0_lock = 1'b0, req1_lock = 1'b0;
`endif
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp_f;
  logic [3:0]  rsp_flags;
  logic [31:0] fu_a, fu_b, fu_f;
  logic [3:0]  fu_fs;
  logic        fu_v, fu_c, fu_n, fu_z;
  logic        busy;

  always #5 clk = ~clk;

  // FU stub: F = A + B, Z from the result, other flags clear.
  assign fu_f = fu_a + fu_b;
  assign fu_z = (fu_f == 32'd0);
  assign fu_v = 1'b0;
  assign fu_c = 1'b0;
  assign fu_n = 1'b0;

  fu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_fs    (req0_fs),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_fs    (req1_fs),
`ifdef FU_ARB_LOCK_EN
    .req0_lock  (req0_lock),
    .req1_lock  (req1_lock),
`endif
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_f      (rsp_f),
    .rsp_flags  (rsp_flags),
    .fu_a       (fu_a),
    .fu_b       (fu_b),
    .fu_fs      (fu_fs),
    .fu_f       (fu_f),
    .fu_v       (fu_v),
    .fu_c       (fu_c),
    .fu_n       (fu_n),
    .fu_z       (fu_z),
    .busy       (busy)
  );

  typedef struct {
    int          owner;
    logic [31:0] f;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int owner, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.owner = owner;
    e.f     = a + b;
    e.flags = {3'b000, (e.f == 32'd0)};
    return e;
  endfunction

  task automatic pop_check(input int r);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("rsp_owner", r, e.owner);
      check("rsp_f", rsp_f, e.f);
      check("rsp_flags", rsp_flags, e.flags);
    end
  endtask

  // Monitor: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (req0_ready || req1_ready)
        check("ready_onehot", {req1_ready, req0_ready} == 2'b11, 1'b0);
      if (req0_valid && req0_ready) begin
        sb.push_back(model(0, req0_a, req0_b));
        grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(model(1, req1_a, req1_b));
        grant_log.push_back(1);
      end
      if (rsp0_valid && rsp1_valid)
        check("rsp_onehot", 1'b1, 1'b0);
      if (rsp0_valid && rsp0_ready) pop_check(0);
      if (rsp1_valid && rsp1_ready) pop_check(1);
    end
  end

  // Returns at the first falling edge where the selected condition holds.
  task automatic wait_cond(input int which, input string tag);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = req0_ready;
        1: hit = req1_ready;
        2: hit = rsp0_valid;
        3: hit = rsp1_valid;
        default: hit = !busy;
      endcase
    end
    if (!hit) check({"timeout_", tag}, 64'd0, 64'd1);
  endtask

  task automatic send(input int r, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] fs);
    @(posedge clk); #1;
    if (r == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fs = fs;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fs = fs;
    end
    wait_cond(r, r == 0 ? "req0_ready" : "req1_ready");
    @(posedge clk); #1;
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_fu_a", fu_a, 32'd0);
    check("rst_fu_fs", fu_fs, 4'd0);
    check("rst_rsp_f", rsp_f, 32'd0);
    check("rst_valids", {rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 4'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single op with cycle-exact latency
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_fs = 4'h1;
    wait_cond(0, "single_ready");
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("single_fu_a", fu_a, 32'd5);
    check("single_fu_b", fu_b, 32'd7);
    check("single_fu_fs", fu_fs, 4'h1);
    check("single_ready_pulse", req0_ready, 1'b0);
    check("single_exec_busy", busy, 1'b1);
    check("single_exec_rsp0", rsp0_valid, 1'b0);
    @(negedge clk);
    check("single_rsp0_valid", rsp0_valid, 1'b1);
    check("single_rsp1_valid", rsp1_valid, 1'b0);
    check("single_rsp_f", rsp_f, 32'd12);
    check("single_rsp_flags", rsp_flags, 4'b0000);
    wait_cond(4, "single_idle");

    // Contention from reset: expect alternation 0,1,0,1
    pulse_reset();
    grant_log.delete();
    fork
      send(0, 32'd10, 32'd1, 4'h2);
      send(1, 32'd20, 32'd2, 4'h3);
    join
    fork
      send(0, 32'd30, 32'd3, 4'h4);
      send(1, 32'd40, 32'd4, 4'h5);
    join
    wait_cond(4, "cont_idle");
    check("cont_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("cont_order", grant_log[i], i % 2);

    // Backpressure on rsp0 with req1 pending
    rsp0_ready = 1'b0;
    send(0, 32'd100, 32'd23, 4'h2);
    fork
      send(1, 32'd1, 32'd2, 4'h3);
      begin
        wait_cond(2, "bp_rsp0");
        repeat (10) begin
          @(negedge clk);
          check("bp_rsp0_valid", rsp0_valid, 1'b1);
          check("bp_rsp_f", rsp_f, 32'd123);
          check("bp_req1_ready", req1_ready, 1'b0);
          check("bp_busy", busy, 1'b1);
        end
        @(posedge clk); #1 rsp0_ready = 1'b1;
      end
    join
    wait_cond(4, "bp_idle");

    // Zero flag
    send(1, 32'hFFFF_FFFF, 32'd1, 4'h0);
    wait_cond(3, "zero_rsp1");
    check("zero_rsp_f", rsp_f, 32'd0);
    check("zero_flag_z", rsp_flags[0], 1'b1);
    wait_cond(4, "zero_idle");

    // Reset while in RESP with req1 pending; in-flight result is dropped
    rsp0_ready = 1'b0;
    send(0, 32'd9, 32'd9, 4'h0);
    wait_cond(2, "rr_rsp0");
    @(posedge clk); #1;
    rst = 1'b1;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_fs = 4'h1;
    @(posedge clk);
    @(negedge clk);
    check("rr_valids", {rsp1_valid, rsp0_valid, req1_ready, req0_ready}, 4'd0);
    check("rr_rsp_f", rsp_f, 32'd0);
    check("rr_rsp_flags", rsp_flags, 4'd0);
    check("rr_busy", busy, 1'b0);
    check("rr_fu_a", fu_a, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp0_ready = 1'b1;
    grant_log.delete();
    @(negedge clk);
    check("rr_req1_first", req1_ready, 1'b1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_cond(4, "rr_idle");
    check("rr_grant_owner", grant_log.size() > 0 ? grant_log[0] : -1, 1);

`ifdef FU_ARB_LOCK_EN
    // Locked owner keeps priority; dropping the lock hands over to req1
    grant_log.delete();
    req0_lock = 1'b1;
    fork
      begin
        send(0, 32'd1, 32'd1, 4'h6);
        send(0, 32'd2, 32'd2, 4'h0);
        send(0, 32'd3, 32'd3, 4'h0);
        req0_lock = 1'b0;
      end
      send(1, 32'd50, 32'd5, 4'h0);
    join
    wait_cond(4, "lock_idle");
    check("lock_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("lock_order", grant_log[i], (i == 3) ? 1 : 0);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
